dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder: the slave end of the MEM-stage load/store interface.
- Accepts one word-wide request at a time over a valid/ready channel.
- Applies a configurable access latency, decodes the address window and performs byte-strobed writes or word reads on an internal array.
- Returns a response on a valid/ready channel with read data and an error flag.
- Sits between the MEM pipeline stage and the on-chip data RAM; D_MEM_START_ADDR feeds BASE_ADDR.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes)
BASE_ADDR, 32'h1000_0000, first byte address of the window
MEM_DEPTH, 1024, number of 32-bit words
LATENCY, 1, cycles from request accept to rsp_valid; legal range 1..15

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_addr  in  ADDR_WIDTH  byte address
req_we  in  1  1 = write, 0 = read
req_wdata  in  DATA_WIDTH  write data
req_wstrb  in  4  byte-lane write enables; bit i covers wdata[8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  requester can take the response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
rsp_err  out  1  access was out of range or misaligned

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All state is captured on the rising edge of clk.
- Reset values: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. Memory array is not reset.
- FSM states:
  - IDLE: req_ready=1. Accept occurs on the edge where req_valid&&req_ready. On accept: if LATENCY==1 go to RESP, else go to WAIT with cnt=LATENCY-1.
  - WAIT: req_ready=0. cnt decrements each cycle; at cnt==1 the next state is RESP. rsp_valid is therefore first high exactly LATENCY cycles after the accept edge.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until the rsp_ready edge, then the FSM returns to IDLE. A new request cannot be accepted in the same cycle. Maximum throughput is one request per LATENCY+1 cycles.
- Decode at accept:
  - off = req_addr - BASE_ADDR, computed as unsigned ADDR_WIDTH.
  - Error if req_addr < BASE_ADDR, or off >= MEM_DEPTH*4, or req_addr[1:0] != 0.
  - Word index = off[ADDR_WIDTH-1:2].
- Write: committed to the array on the accept edge, only for lanes with wstrb=1. wstrb=0000 performs no change but still gets a normal response. Response has rsp_rdata=0, rsp_err=0.
- Read: array word sampled on the accept edge and held in the response register. Read data reflects all previously accepted writes.
- Error: no array write; rsp_rdata=0, rsp_err=1.
- Requester inputs are ignored outside IDLE.
- Reset mid-operation: any pending response is discarded; the FSM returns to IDLE. Writes already accepted remain in the array.

Optional Feature:
DMEM_STATS_EN
- Defined: adds outputs stat_reads, stat_writes and stat_errs (16 bits each).
  - Saturating counters, reset to 0.
  - Incremented on the accept edge: reads, writes, and errors respectively. An error request counts only as an error.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- LATENCY=1, write 0xDEADBEEF to 0x1000_0010 with wstrb=1111, then read it back -> rsp_valid 1 cycle after each accept; read returns 0xDEADBEEF, rsp_err=0.
- Word 0x1000_0020 holds 0x11223344; write 0x0000AA00 with wstrb=0010, then read -> read returns 0x1122AA44.
- LATENCY=4: read request accepted at cycle t -> rsp_valid rises at t+4; req_ready=0 during t+1..t+4.
- Reads of 0x0FFF_FFFC, 0x1000_1000 and 0x1000_0002 -> each gives rsp_err=1, rsp_rdata=0; a following read of the lowest word in range (0x1000_0000) is unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable throughout; a req_valid pulse in that window is not accepted.
- Assert reset_n=0 during WAIT -> rsp_valid=0 and req_ready=1 immediately. With DMEM_STATS_EN, 2 reads + 1 write + 1 error gives stat_reads=2, stat_writes=1, stat_errs=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: MEM-stage load/store slave with configurable latency and byte-strobed writes.
// Optional DMEM_STATS_EN macro adds saturating read/write/error counters.
module dmem_responder #(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned            MEM_DEPTH  = 1024,
    parameter int unsigned            LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
`ifdef DMEM_STATS_EN
   ,output logic [15:0]           stat_reads
   ,output logic [15:0]           stat_writes
   ,output logic [15:0]           stat_errs
`endif
);

    localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned AW1    = ADDR_WIDTH + 1;
    localparam int unsigned NLANES = 4;
    localparam logic [AW1-1:0] WIN_BYTES = AW1'(64'(MEM_DEPTH) * 64'd4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic                    accept_c;
    logic [ADDR_WIDTH-1:0]   off_c;
    logic                    addr_err_c;
    logic [IDX_W-1:0]        idx_c;
    logic [NLANES-1:0]       lane_we_c;

    // Address window decode; an out-of-window offset never reaches the array
    always_comb begin
        accept_c   = req_valid && req_ready_q;
        off_c      = req_addr - BASE_ADDR;
        addr_err_c = (req_addr < BASE_ADDR)
                  || ({1'b0, off_c} >= WIN_BYTES)
                  || (req_addr[1:0] != 2'b00);
        idx_c      = off_c[IDX_W+1:2];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        lane_we_c   = '0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    req_ready_d = 1'b0;
                    rsp_err_d   = addr_err_c;
                    rsp_rdata_d = (addr_err_c || req_we) ? '0 : mem_q[idx_c];
                    lane_we_c   = (!addr_err_c && req_we) ? req_wstrb : '0;
                    if (LATENCY == 1) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = RESP;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

`ifdef DMEM_STATS_EN
    logic [15:0] stat_reads_q, stat_reads_d;
    logic [15:0] stat_writes_q, stat_writes_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    // An erroring request counts only as an error, never as a read or write
    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        stat_errs_d   = stat_errs_q;
        if (accept_c) begin
            if (addr_err_c) begin
                if (stat_errs_q != 16'hFFFF) stat_errs_d = stat_errs_q + 16'd1;
            end else if (req_we) begin
                if (stat_writes_q != 16'hFFFF) stat_writes_d = stat_writes_q + 16'd1;
            end else begin
                if (stat_reads_q != 16'hFFFF) stat_reads_d = stat_reads_q + 16'd1;
            end
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
    assign stat_errs   = stat_errs_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
`ifdef DMEM_STATS_EN
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
            stat_errs_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
`ifdef DMEM_STATS_EN
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
            stat_errs_q   <= stat_errs_d;
`endif
        end
    end

    // Array is deliberately not reset so accepted writes survive a mid-operation reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NLANES; i++) begin
            if (lane_we_c[i]) begin
                mem_q[idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
